// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: default sizes, FSM state
// encoding and the requester-ID width helper.
package mult_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a requester index; never less than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_core.sv
// Iterative signed shift-add multiplier. Operands are sign-extended to 2*W
// bits and one add/shift step is taken per cycle for 2*W cycles, which gives
// the exact two's-complement product modulo 2^(2*W).
// start : loads the operands (one step per cycle follows from the next edge).
// done  : high during the cycle whose closing edge performs the last step;
//         p takes the product on that edge and holds it until the next one.
module mult_core
  import mult_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] p
);

  localparam int PW = 2 * W;
  localparam int CW = $clog2(PW);
  localparam logic [CW-1:0] LAST = CW'(PW - 1);

  logic [PW-1:0] acc;
  logic [PW-1:0] mcand;
  logic [PW-1:0] mplier;
  logic [PW-1:0] acc_next;
  logic [CW-1:0] ctr;
  logic          running;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = running && (ctr == LAST);

  // Operand load on start, then one shift-add step per cycle until the last.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      ctr     <= '0;
      running <= 1'b0;
      p       <= '0;
    end else if (start) begin
      acc     <= '0;
      mcand   <= {{W{a[W-1]}}, a};
      mplier  <= {{W{b[W-1]}}, b};
      ctr     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      ctr    <= ctr + CW'(1);
      if (done) begin
        running <= 1'b0;
        p       <= acc_next;
      end
    end
  end

endmodule

// File: rtl/mult_arb.sv
// Arbiter in front of a single shared iterative multiplier.
// Optional feature: define MULT_ARB_RR_EN for round-robin arbitration
// (search starts after the last winner); otherwise lowest index wins.
// Handshake: req[k] is a level held until gnt[k]; gnt is a one-cycle pulse
// on the edge that captures operand slice k; requests seen while busy are
// ignored. res_valid pulses once per operation with res_p/res_id, which then
// hold until the next result.
module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*W-1:0]       a_in,
  input  logic [NREQ*W-1:0]       b_in,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    res_valid,
  output logic [id_w(NREQ)-1:0]   res_id,
  output logic [2*W-1:0]          res_p,
  output state_t                  dbg_state
);

  localparam int IDW = id_w(NREQ);

  state_t         state;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] owner;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           start;
  logic           core_done;

`ifdef MULT_ARB_RR_EN
  logic [IDW-1:0] rr_ptr;

  // Round-robin pick: first requester after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req[(int'(rr_ptr) + 1 + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(rr_ptr) + 1 + i) % NREQ);
      end
    end
  end
`else
  // Fixed-priority pick: lowest requesting index wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = IDW'(i);
      end
    end
  end
`endif

  assign op_a      = a_in[int'(win_idx) * W +: W];
  assign op_b      = b_in[int'(win_idx) * W +: W];
  assign start     = (state == IDLE) && win_found;
  assign dbg_state = state;

  mult_core #(.W(W)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (op_a),
    .b       (op_b),
    .done    (core_done),
    .p       (res_p)
  );

  // Control FSM: grant in IDLE, wait for the core in RUN, publish in DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      owner     <= '0;
`ifdef MULT_ARB_RR_EN
      rr_ptr    <= IDW'(NREQ - 1);
`endif
    end else begin
      gnt       <= '0;
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt   <= NREQ'(1) << win_idx;
            owner <= win_idx;
            busy  <= 1'b1;
            state <= RUN;
`ifdef MULT_ARB_RR_EN
            rr_ptr <= win_idx;
`endif
          end
        end
        RUN: begin
          if (core_done) begin
            res_valid <= 1'b1;
            res_id    <= owner;
            state     <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arb.sv
// Directed bench for mult_arb: single operations with hand-computed signed
// products, arbitration order with all requests held, requests during busy,
// and reset in the middle of an operation.
module tb_mult_arb;
  import mult_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = id_w(NREQ);

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*W-1:0]     a_in;
  logic [NREQ*W-1:0]     b_in;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [2*W-1:0]        res_p;
  state_t                dbg_state;

  int total     = 0;
  int passed    = 0;
  int gnt_cnt   = 0;
  int valid_cnt = 0;

  mult_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_p     (res_p),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // one clock; outputs are sampled 1 ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (gnt != '0) gnt_cnt++;
    if (res_valid) valid_cnt++;
  endtask

  task automatic wait_gnt(input int max, output int n);
    n = 0;
    while (gnt == '0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[k*W +: W] = a;
    b_in[k*W +: W] = b;
  endtask

  // one complete operation on requester k with cycle-exact checks
  task automatic run_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input string tag);
    set_ops(k, a, b);
    req = NREQ'(1) << k;
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(NREQ'(1) << k));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    req = '0;
    valid_cnt = 0;
    repeat (15) tick();
    chk({tag, "_early_valid"}, 32'(valid_cnt), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_p"}, 32'(res_p), 32'(exp_p));
    chk({tag, "_id"}, 32'(res_id), 32'(k));
    tick();
    chk({tag, "_valid_pulse"}, 32'(res_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_p_hold"}, 32'(res_p), 32'(exp_p));
  endtask

  initial begin
    int n;
    int exp_order[5];
    int n_exp;
`ifdef MULT_ARB_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
    n_exp     = 5;
`else
    exp_order = '{0, 0, 0, 0, 0};
    n_exp     = 3;
`endif

    // reset
    reset_n = 1'b0;
    req     = '0;
    a_in    = '0;
    b_in    = '0;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_p", 32'(res_p), 32'd0);
    chk("rst_id", 32'(res_id), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    reset_n = 1'b1;
    tick();

    // basic operation and signed corners
    run_op(1, 8'd3, 8'd5, 16'h000F, "r1_3x5");
    run_op(0, 8'h80, 8'h80, 16'h4000, "m128xm128");
    run_op(2, 8'h7F, 8'h80, 16'hC080, "p127xm128");
    run_op(3, 8'hFF, 8'hFF, 16'h0001, "m1xm1");
    run_op(1, 8'h00, 8'hB3, 16'h0000, "0xm77");

    // req[2] raised while requester 0 runs, then a one-cycle req[0] pulse while busy
    set_ops(0, 8'd4, 8'd4);
    req = 4'b0001;
    tick();
    chk("late_gnt0", 32'(gnt), 32'b0001);
    req = '0;
    repeat (4) tick();
    set_ops(2, 8'd7, 8'hFD);
    req = 4'b0100;
    wait_gnt(40, n);
    chk("late_gnt2_wait", 32'(n), 32'd14);
    chk("late_gnt2", 32'(gnt), 32'b0100);
    chk("late_prev_p", 32'(res_p), 32'h0010);
    chk("late_prev_id", 32'(res_id), 32'd0);
    req = '0;
    gnt_cnt = 0;
    valid_cnt = 0;
    repeat (3) tick();
    req = 4'b0001;
    tick();
    req = '0;
    wait_valid(40, n);
    chk("late_latency", 32'(n), 32'd12);
    chk("late_p", 32'(res_p), 32'hFFEB);
    chk("late_id", 32'(res_id), 32'd2);
    repeat (4) tick();
    chk("pulse_no_gnt", 32'(gnt_cnt), 32'd0);
    chk("pulse_one_result", 32'(valid_cnt), 32'd1);
    chk("pulse_idle", 32'(busy), 32'd0);

    // reset at RUN cycle 8
    set_ops(0, 8'd5, 8'd5);
    req = 4'b0001;
    tick();
    chk("mid_gnt", 32'(gnt), 32'b0001);
    req = '0;
    repeat (8) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_p", 32'(res_p), 32'd0);
    chk("mid_rst_id", 32'(res_id), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    repeat (2) tick();
    reset_n = 1'b1;
    gnt_cnt = 0;
    valid_cnt = 0;
    repeat (20) tick();
    chk("mid_no_result", 32'(valid_cnt), 32'd0);
    chk("mid_no_gnt", 32'(gnt_cnt), 32'd0);
    run_op(3, 8'd2, 8'd3, 16'h0006, "post_rst_2x3");

    // all requests held: grant order and 18-cycle spacing
    set_ops(0, 8'd1, 8'd1);
    set_ops(1, 8'd2, 8'd2);
    set_ops(2, 8'd3, 8'd3);
    set_ops(3, 8'd4, 8'd4);
    req = '1;
    for (int g = 0; g < n_exp; g++) begin
      if (g > 0) tick();
      wait_gnt(40, n);
      chk("allreq_gnt", 32'(gnt), 32'(NREQ'(1) << exp_order[g]));
      if (g > 0) chk("allreq_gap", 32'(n + 1), 32'd18);
    end
    req = '0;
    wait_valid(40, n);
    chk("allreq_latency", 32'(n), 32'd16);
    chk("allreq_last_id", 32'(res_id), 32'(exp_order[n_exp-1]));
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_arb.md
MULT_ARB -- requirements
Module: mult_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the multiplier.
REQ-002 SHALL have parameter W, default 8, operand width in bits; product width is 2*W.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  NREQ  per-requester request, level, held until gnt.
REQ-006 SHALL have port a_in  input  NREQ*W  packed operand A per requester; slice k is [k*W +: W], two's complement.
REQ-007 SHALL have port b_in  input  NREQ*W  packed operand B per requester, same packing.
REQ-008 SHALL have port gnt  output  NREQ  one-hot, one-cycle grant pulse; operands captured on the same edge.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port res_valid  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port res_id  output  clog2(NREQ)  index of the requester owning res_p.
REQ-012 SHALL have port res_p  output  2*W  signed product.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with any req bit high at edge E0: select winner k, register a_in/b_in slice k and pulse gnt[k] for one cycle; enter RUN with ctr=0.
REQ-015 SHALL, in RUN, perform one shift-add step per cycle on sign-extended 2*W operands for 2*W cycles (16 at default).
REQ-016 SHALL, at E16, enter DONE with res_p = product, res_id = k and res_valid pulsed for one cycle; at E17 return to IDLE.
REQ-017 SHALL hold res_p and res_id stable after DONE until the next result.
REQ-018 SHALL produce res_p equal to the signed product a*b, exact for all inputs (no overflow at W=8, since -128*-128 = 0x4000).
REQ-019 SHALL ignore req while busy; it is neither queued nor granted until IDLE.
REQ-020 SHALL capture nothing and raise no error if req drops before a grant.
REQ-021 SHALL grant at most one requester per operation; throughput is one result per 18 cycles and grant-edge-to-res_valid latency is 16 cycles.

Reset
REQ-022 SHALL, on reset_n low, immediately force state=IDLE, gnt=0, busy=0, res_valid=0, res_p=0, res_id=0, ctr=0 and rr_ptr=NREQ-1.
REQ-023 SHALL discard any in-flight operation on reset and emit no res_valid for it.

Configuration
REQ-024 SHALL, with MULT_ARB_RR_EN defined, arbitrate round-robin: search starts at rr_ptr+1 modulo NREQ, and rr_ptr updates to k on each grant.
REQ-025 SHALL, without MULT_ARB_RR_EN, use fixed priority with the lowest index winning; rr_ptr is absent.

Structure
REQ-026 SHALL take NREQ/W defaults, the state enum, and the ID-width function from shared package mult_arb_pkg.
REQ-027 SHALL instantiate one sub-module, mult_core: iterative signed shift-add multiplier with ports start, a, b, done and p. The arbiter/FSM lives in mult_arb.

Verification
REQ-028 SHALL verify: req[1] only, a=3, b=5 -> gnt[1] pulse at E0; res_valid 16 cycles later with res_p=15 (0x000F) and res_id=1.
REQ-029 SHALL verify signed corners: -128*-128 -> 0x4000; 127*-128 -> 0xC080; -1*-1 -> 0x0001; 0*-77 -> 0x0000.
REQ-030 SHALL verify all req held high -> with MULT_ARB_RR_EN, grant order 0,1,2,3,0; without it, grant order 0,0,0.
REQ-031 SHALL verify req[2] raised during RUN of requester 0 -> no gnt[2] until after DONE; then gnt[2] at the first IDLE edge.
REQ-032 SHALL verify reset_n low at RUN cycle 8 -> all outputs 0 and no res_valid; after release, a new req[3] with 2*3 yields res_p=6 and res_id=3.
REQ-033 SHALL verify req[0] pulsed for one cycle while busy, then dropped -> no grant and no result for requester 0.
